// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one two-phase memory bus between the fetch and data ports, with VA->PA mapping.
// Define ARB_RR_EN for round-robin arbitration; the default build gives the data port fixed priority.
module mem_bus_arbiter #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_ack_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ack_o,
    output logic        err_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_cache_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nx;
    logic owner;
    logic [7:0] cnt;
    logic grant, grant_data, timeout, done, cache;
    logic [31:0] va, pa, rdata_in;
`ifdef ARB_RR_EN
    logic last_grant;
    assign grant_data = data_req_i & ~(inst_req_i & last_grant);
`else
    assign grant_data = data_req_i;
`endif
    // No grant during an ack cycle: the acked requester still holds req until it sees the ack.
    assign grant = (inst_req_i | data_req_i) & ~inst_ack_o & ~data_ack_o;
    assign va = grant_data ? data_addr_i : inst_addr_i;
    assign pa = (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
    assign cache = va[31:29] != 3'b101;
    assign timeout = cnt == 8'(WAIT_MAX - 1);
    assign done = bus_data_ok_i | timeout;
    assign rdata_in = bus_data_ok_i ? bus_rdata_i : 32'h0;
    assign stallreq_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? ADDR : IDLE;
            ADDR:    state_nx = bus_addr_ok_i ? DATA : ADDR;
            DATA:    state_nx = done ? IDLE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= 4'h0;
            bus_addr_o   <= 32'h0;
            bus_wdata_o  <= 32'h0;
            bus_cache_o  <= 1'b0;
            inst_ack_o   <= 1'b0;
            data_ack_o   <= 1'b0;
            err_o        <= 1'b0;
            inst_rdata_o <= 32'h0;
            data_rdata_o <= 32'h0;
            owner        <= 1'b1;
            cnt          <= 8'h0;
`ifdef ARB_RR_EN
            last_grant   <= 1'b0;
`endif
        end else begin
            inst_ack_o <= 1'b0;
            data_ack_o <= 1'b0;
            err_o      <= 1'b0;
            if (state == IDLE && grant) begin
                owner       <= grant_data;
                bus_req_o   <= 1'b1;
                bus_we_o    <= grant_data & data_we_i;
                bus_sel_o   <= grant_data ? data_sel_i : 4'hF;
                bus_addr_o  <= pa;
                bus_wdata_o <= grant_data ? data_wdata_i : 32'h0;
                bus_cache_o <= cache;
`ifdef ARB_RR_EN
                last_grant  <= grant_data;
`endif
            end
            if (state == ADDR && bus_addr_ok_i) begin
                bus_req_o <= 1'b0;
                cnt       <= 8'h0;
            end
            if (state == DATA) begin
                cnt <= cnt + 8'd1;
                if (done) begin
                    inst_ack_o   <= ~owner;
                    data_ack_o   <= owner;
                    err_o        <= ~bus_data_ok_i;
                    inst_rdata_o <= owner ? inst_rdata_o : rdata_in;
                    data_rdata_o <= owner ? rdata_in : data_rdata_o;
                end
            end
        end
    end
endmodule
